// File: rtl/arb_pkg.sv
// Shared constants and FSM encoding for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;

  logic                          en;
  logic [arb_pkg::N_REQ-1:0]     req;
  logic [arb_pkg::N_REQ-1:0]     gnt;
  logic [arb_pkg::ID_W-1:0]      gnt_id;
  logic                          gnt_valid;
  logic                          timeout;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_prio_enc8.sv
// Rotating priority encoder: first set request after ptr_i (wrapping) wins.
module rr_prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  win_id_o,
  output logic             any_o
);

  logic [ID_W-1:0] idx;

  // Walk from the farthest position back to ptr+1 so the nearest hit overwrites.
  always_comb begin
    win_id_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr_i + ID_W'(i) + ID_W'(1);
      if (req_i[idx]) begin
        win_id_o = idx;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with grant hold limit and turnaround cycle.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter8_if.slave  arb_if
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]     hold_q, hold_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;

  logic [ID_W-1:0]   win_id;
  logic              win_any;

  rr_prio_enc8 u_prio_enc (
    .req_i    (arb_if.req),
    .ptr_i    (ptr_q),
    .win_id_o (win_id),
    .any_o    (win_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d   = '0;
        id_d    = '0;
        valid_d = 1'b0;
        if (arb_if.en && win_any) begin
          state_d        = ST_GRANT;
          ptr_d          = win_id;
          hold_d         = CW'(1);
          gnt_d[win_id]  = 1'b1;
          id_d           = win_id;
          valid_d        = 1'b1;
        end
      end

      ST_GRANT: begin
        // A request drop takes precedence over the hold limit, so no timeout then.
        if (!arb_if.req[id_q]) begin
          state_d = ST_RELEASE;
          hold_d  = '0;
          gnt_d   = '0;
          id_d    = '0;
          valid_d = 1'b0;
        end else if (hold_q >= CW'(MAX_HOLD)) begin
          state_d   = ST_RELEASE;
          hold_d    = '0;
          gnt_d     = '0;
          id_d      = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
        gnt_d   = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= ID_W'(N_REQ - 1);
      hold_q    <= '0;
      gnt_q     <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign arb_if.gnt       = gnt_q;
  assign arb_if.gnt_id    = id_q;
  assign arb_if.gnt_valid = valid_q;
  assign arb_if.timeout   = timeout_q;

  a_gnt_onehot0:   assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_valid_match:   assert property (@(posedge clk) disable iff (rst) valid_q == |gnt_q);
  a_id_match:      assert property (@(posedge clk) disable iff (rst) valid_q |-> gnt_q[id_q]);
  a_id_idle_zero:  assert property (@(posedge clk) disable iff (rst) !valid_q |-> id_q == '0);
  a_timeout_idle:  assert property (@(posedge clk) disable iff (rst) timeout_q |-> !valid_q);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed-vector bench for rr_arbiter8 built with a hold limit of 4.
module tb_rr_arbiter8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(
    .MAX_HOLD (4),
    .CW       (5)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                           input logic v, input logic to);
    check_eq({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
    check_eq({tag, "_id"}, 32'(bus.gnt_id), 32'(id));
    check_eq({tag, "_valid"}, 32'(bus.gnt_valid), 32'(v));
    check_eq({tag, "_timeout"}, 32'(bus.timeout), 32'(to));
  endtask

  // Advance until gnt_valid reaches lvl, bounded; an expired bound shows as a failed check.
  task automatic wait_valid(input logic lvl, input string tag);
    int n;
    n = 0;
    while (bus.gnt_valid !== lvl && n < 12) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(bus.gnt_valid), 32'(lvl));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    tick();
    rst     = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.en   = 1'b1;
    bus.req  = '0;
    rst      = 1'b1;

    // 1: single requester, normal release coinciding with the hold limit edge
    do_reset();
    check_out("t1_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.req = 8'h01;
    tick();
    check_out("t1_c1", 8'h01, 3'd0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    check_out("t1_c4", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    check_out("t1_c5_release", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check_out("t1_c6_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // 2: all requesting, each winner drops two cycles after its grant
    do_reset();
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] eg;
      logic [2:0] ei;
      ei = 3'(k % 8);
      eg = 8'h01 << ei;
      wait_valid(1'b1, "t2_wait_grant");
      check_eq("t2_order_id", 32'(bus.gnt_id), 32'(ei));
      check_eq("t2_order_gnt", 32'(bus.gnt), 32'(eg));
      tick();
      bus.req[ei] = 1'b0;
      tick();
      check_eq("t2_release", 32'(bus.gnt_valid), 32'(0));
      bus.req = 8'hFF;
    end

    // 3: sole requester held past the limit -> timeout pulse, then regrant
    do_reset();
    bus.req = 8'h08;
    tick();
    check_out("t3_c1", 8'h08, 3'd3, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    check_out("t3_c4", 8'h08, 3'd3, 1'b1, 1'b0);
    tick();
    check_out("t3_c5_timeout", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    check_out("t3_c6_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check_out("t3_c7_regrant", 8'h08, 3'd3, 1'b1, 1'b0);

    // 4: ptr=3 after grant to 3, req=0x28 -> 5 then 3
    bus.req = 8'h28;
    wait_valid(1'b0, "t4_rel3");
    check_eq("t4_timeout3", 32'(bus.timeout), 32'(1));
    wait_valid(1'b1, "t4_grant5");
    check_eq("t4_id5", 32'(bus.gnt_id), 32'(5));
    wait_valid(1'b0, "t4_rel5");
    wait_valid(1'b1, "t4_grant3");
    check_eq("t4_id3", 32'(bus.gnt_id), 32'(3));

    // 5: reset in the middle of a grant to 6
    do_reset();
    bus.req = 8'h40;
    tick();
    check_out("t5_grant6", 8'h40, 3'd6, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_out("t5_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst     = 1'b0;
    bus.req = 8'h41;
    tick();
    check_out("t5_grant0", 8'h01, 3'd0, 1'b1, 1'b0);

    // 6: en blocks new grants only
    do_reset();
    bus.en  = 1'b0;
    bus.req = 8'h10;
    tick();
    tick();
    tick();
    check_out("t6_blocked", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.en = 1'b1;
    tick();
    check_out("t6_grant4", 8'h10, 3'd4, 1'b1, 1'b0);
    bus.en = 1'b0;
    tick();
    tick();
    check_out("t6_persist", 8'h10, 3'd4, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    check_out("t6_release", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.req = 8'h10;
    tick();
    tick();
    tick();
    check_out("t6_blocked_again", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
